// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 1250;

  // x is the XOR of all data bits and the received parity bit
  function automatic logic parity_bad(input int mode, input logic x);
    if (mode == PARITY_EVEN) return x;
    if (mode == PARITY_ODD)  return ~x;
    return 1'b0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with registered head word
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sysclk,
  input  logic                     sysrst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    next_rd;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign next_rd = rd_ptr + AW'(do_pop);

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // The head register tracks the slot rd_ptr will point at; when that slot is
  // being written this cycle the incoming word bypasses the array.
  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= next_rd;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      rdata  <= (do_push && (wr_ptr == next_rd)) ? wdata : mem[next_rd];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with error pulses feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          sysclk,
  input  logic                          sysrst_n,
  input  logic                          uart_txd_in,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_t          state, state_nxt;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic               rx_d;
  logic [CW-1:0]      timer;
  logic [BW-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic               par_bit;
  logic               tick;
  logic               timer_clr;
  logic               shift_en;
  logic               par_en;
  logic               push;
  logic               frame_err_c;
  logic               parity_err_c;
  logic               fifo_full;
  logic               fifo_empty;

  assign rx_s = sync_q[1];
  assign tick = (state == START) ? (timer == CW'(HALF - 1))
                                 : (timer == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      state   <= IDLE;
      sync_q  <= 2'b11;
      rx_d    <= 1'b1;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state  <= state_nxt;
      sync_q <= {sync_q[0], uart_txd_in};
      rx_d   <= rx_s;
      timer  <= timer_clr ? '0 : timer + CW'(1);
      if (state == IDLE) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BW'(1);
      if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
      if (par_en) par_bit <= rx_s;
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_clr    = 1'b0;
    shift_en     = 1'b0;
    par_en       = 1'b0;
    push         = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (rx_d && !rx_s) state_nxt = START;
      end
      START: begin
        if (tick) begin
          timer_clr = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1))
            state_nxt = (PARITY != PARITY_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (tick) begin
          timer_clr = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          timer_clr = 1'b1;
          if (rx_s) begin
            state_nxt = IDLE;
            if (parity_bad(PARITY, ^shift ^ par_bit)) parity_err_c = 1'b1;
            else push = 1'b1;
          end else begin
            frame_err_c = 1'b1;
            state_nxt   = BREAK;
          end
        end
      end
      BREAK: begin
        timer_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .sysrst_n (sysrst_n),
    .push     (push),
    .pop      (m_ready),
    .wdata    (shift),
    .rdata    (m_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign m_valid    = !fifo_empty;
  assign frame_err  = frame_err_c && sysrst_n;
  assign parity_err = parity_err_c && sysrst_n;
  assign overrun    = push && fifo_full && !(m_ready && m_valid) && sysrst_n;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed checks of uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB      = 16;
  localparam int DB       = 8;
  localparam int DEPTH    = 16;
  localparam int SYNC_LAT = 2;
  localparam int STOP_OFS = SYNC_LAT + CPB / 2 + (DB + 2) * CPB;
  localparam int A_CPB    = 1250;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       sysrst_n, txd, m_ready;
  logic [7:0] m_data;
  logic       m_valid, frame_err, parity_err, overrun;
  logic [4:0] fifo_count;

  logic       a_rst_n, a_txd, a_ready;
  logic [7:0] a_data;
  logic       a_valid, a_ferr, a_perr, a_ovr;
  logic [4:0] a_count;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(1), .FIFO_DEPTH(DEPTH)) dut_b (
    .sysclk(sysclk), .sysrst_n(sysrst_n), .uart_txd_in(txd),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
    .fifo_count(fifo_count)
  );

  uart_rx_fifo dut_a (
    .sysclk(sysclk), .sysrst_n(a_rst_n), .uart_txd_in(a_txd),
    .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
    .frame_err(a_ferr), .parity_err(a_perr), .overrun(a_ovr),
    .fifo_count(a_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected FIFO contents plus scheduled stop-sample outcomes
  // (1 = good word, 2 = parity error, 3 = framing error) keyed by cycle.
  logic [7:0] exp_q[$];
  logic [7:0] drained[$];
  int   ev_kind[int];
  logic [7:0] ev_word[int];
  logic rst_seen = 1'b1;
  int   ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  logic [7:0] last_pop = '0;
  int   rdy_mode = 1;

  always @(posedge sysclk) rst_seen <= !sysrst_n;

  always @(posedge sysclk) begin
    #2;
    m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
  end

  int   kind;
  logic mpop, movr;
  always @(negedge sysclk) begin
    if (cyc >= 1) begin
      if (rst_seen) begin
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pulses", {frame_err, parity_err, overrun}, 0);
        exp_q.delete();
        ev_kind.delete();
      end else begin
        kind = ev_kind.exists(cyc) ? ev_kind[cyc] : 0;
        mpop = m_ready && (exp_q.size() != 0);
        movr = (kind == 1) && (exp_q.size() == DEPTH) && !mpop;
        check("m_valid", m_valid, exp_q.size() != 0);
        check("fifo_count", fifo_count, exp_q.size());
        if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
        check("frame_err", frame_err, kind == 3);
        check("parity_err", parity_err, kind == 2);
        check("overrun", overrun, movr);
        ferr_cnt += frame_err;
        perr_cnt += parity_err;
        ovr_cnt  += overrun;
        if (m_valid && m_ready) begin
          drained.push_back(m_data);
          last_pop = m_data;
        end
        if (mpop) void'(exp_q.pop_front());
        if (kind == 1 && !movr) exp_q.push_back(ev_word[cyc]);
      end
    end
  end

  int   a_valid_cnt = 0, a_err = 0;
  logic [7:0] a_last = '0;
  always @(negedge sysclk) begin
    if (a_rst_n) begin
      if (a_valid) begin
        a_valid_cnt++;
        a_last = a_data;
      end
      if (a_ferr || a_perr || a_ovr) a_err++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Called aligned to posedge+1; each bit is held exactly CPB cycles.
  task automatic send_b(input logic [7:0] w, input bit par_ok, input bit stop_ok);
    int c;
    c = cyc;
    if (stop_ok) begin
      ev_kind[c + STOP_OFS] = par_ok ? 1 : 2;
      ev_word[c + STOP_OFS] = w;
    end else begin
      ev_kind[c + STOP_OFS] = 3;
    end
    txd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < DB; i++) begin
      txd = w[i];
      wait_cyc(CPB);
    end
    txd = (^w) ^ !par_ok;
    wait_cyc(CPB);
    txd = stop_ok;
    wait_cyc(CPB);
    if (!stop_ok) begin
      wait_cyc(2 * CPB);
      txd = 1'b1;
      wait_cyc(4);
    end
  endtask

  task automatic send_a(input logic [7:0] w);
    a_txd = 1'b0;
    wait_cyc(A_CPB);
    for (int i = 0; i < 8; i++) begin
      a_txd = w[i];
      wait_cyc(A_CPB);
    end
    a_txd = 1'b1;
    wait_cyc(A_CPB);
  endtask

  task automatic run_a();
    send_a(8'hA5);
    wait_cyc(2000);
    check("a_frame_valid_cnt", a_valid_cnt, 1);
    check("a_frame_data", a_last, 8'hA5);
    check("a_frame_errors", a_err, 0);
    a_txd = 1'b0;
    wait_cyc(300);
    a_txd = 1'b1;
    wait_cyc(2000);
    check("a_glitch_valid_cnt", a_valid_cnt, 1);
    check("a_glitch_errors", a_err, 0);
    send_a(8'h3C);
    wait_cyc(2000);
    check("a_after_glitch_cnt", a_valid_cnt, 2);
    check("a_after_glitch_data", a_last, 8'h3C);
    check("a_after_glitch_err", a_err, 0);
  endtask

  task automatic run_b();
    int f0, p0, o0;
    // randomized traffic, random consumer stalls
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        txd = 1'b0;
        wait_cyc(3);
        txd = 1'b1;
        wait_cyc(CPB);
      end
      send_b(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0) wait_cyc($urandom_range(1, 30));
    end
    rdy_mode = 1;
    wait_cyc(40);

    // stop bit low followed by a held-low line, then a normal frame
    f0 = ferr_cnt;
    send_b(8'h3C, 1, 0);
    wait_cyc(10);
    check("break_ferr_pulses", ferr_cnt - f0, 1);
    check("break_fifo_empty", fifo_count, 0);
    send_b(8'h11, 1, 1);
    wait_cyc(20);
    check("after_break_word", last_pop, 8'h11);

    // even parity: 0x07 needs parity bit 1
    p0 = perr_cnt;
    send_b(8'h07, 0, 1);
    wait_cyc(20);
    check("parity_bad_pulse", perr_cnt - p0, 1);
    check("parity_bad_no_push", fifo_count, 0);
    send_b(8'h07, 1, 1);
    wait_cyc(20);
    check("parity_good_word", last_pop, 8'h07);
    check("parity_good_no_err", perr_cnt - p0, 1);

    // fill to overflow with the consumer stalled, then drain
    rdy_mode = 0;
    wait_cyc(4);
    o0 = ovr_cnt;
    for (int i = 0; i <= 16; i++) send_b(8'(i), 1, 1);
    wait_cyc(20);
    check("full_count", fifo_count, 16);
    check("full_overrun_pulses", ovr_cnt - o0, 1);
    drained.delete();
    rdy_mode = 1;
    wait_cyc(40);
    check("drain_size", drained.size(), 16);
    for (int i = 0; i < 16 && i < drained.size(); i++) check("drain_order", drained[i], i);

    // reset during bit 4 of 0xFF
    f0 = ferr_cnt;
    p0 = perr_cnt;
    drained.delete();
    txd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      txd = 1'b1;
      wait_cyc(CPB);
    end
    wait_cyc(4);
    sysrst_n = 1'b0;
    wait_cyc(2);
    sysrst_n = 1'b1;
    wait_cyc(8 * CPB);
    check("reset_no_output", drained.size(), 0);
    check("reset_no_errors", (ferr_cnt - f0) + (perr_cnt - p0), 0);
    send_b(8'h5A, 1, 1);
    wait_cyc(20);
    check("after_reset_word", last_pop, 8'h5A);
    check("after_reset_count", drained.size(), 1);
  endtask

  initial begin
    sysrst_n = 1'b0;
    a_rst_n  = 1'b0;
    txd      = 1'b1;
    a_txd    = 1'b1;
    a_ready  = 1'b1;
    m_ready  = 1'b1;
    wait_cyc(3);
    sysrst_n = 1'b1;
    a_rst_n  = 1'b1;
    wait_cyc(4);
    check("reset_a_count", a_count, 0);
    check("reset_a_valid", a_valid, 0);
    fork
      run_a();
      run_b();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
